// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Reusable inter-stage pipeline register with a valid/ready handshake.
//   It carries a payload, control bits and a destination-register field.
//   SKID=1 adds a second entry so that in_ready comes straight from a flop.
//   SKID=0 keeps a single entry, and in_ready then follows out_ready
//   combinationally.
//   flush inserts a bubble. stall_cnt is a saturating count of the cycles in
//   which downstream held off a valid word.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_data/in_ctrl/in_DstReg   upstream word
//   flush               drop every held word at the next edge
//   out_valid/out_ready downstream handshake
//   out_data/out_ctrl/out_DstReg  held word (out_ctrl is 0 when not valid)
//   stall_cnt           saturating count of out_valid & ~out_ready edges
module pipe_skid_stage #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 5,
  parameter int DST_W  = 4,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DST_W-1:0]  in_DstReg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DST_W-1:0]  out_DstReg,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Each state is encoded as {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_main_data_p1, r_skid_data_p1;
  logic [CTRL_W-1:0] r_main_ctrl_p1, r_skid_ctrl_p1;
  logic [DST_W-1:0]  r_main_dst_p1,  r_skid_dst_p1;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_main_vld, w_skid_vld, w_accept;
  logic w_ld_main_in, w_ld_main_skid, w_ld_skid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign w_main_vld = r_state[0];
  assign w_skid_vld = r_state[1];

  generate
    if (SKID != 0) begin : g_skid
      // Comes only from the state flop, so there is no path from out_ready.
      assign in_ready = ~w_skid_vld;
    end else begin : g_noskid
      assign in_ready = ~w_main_vld | out_ready;
    end
  endgenerate

  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && out_ready) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            // Only reachable when SKID=1. With SKID=0, in_ready needs out_ready here.
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (out_ready) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // ---- stage boundary: held word registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data_p1 <= '0;
      r_main_ctrl_p1 <= '0;
      r_main_dst_p1  <= '0;
      r_skid_data_p1 <= '0;
      r_skid_ctrl_p1 <= '0;
      r_skid_dst_p1  <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_data_p1 <= in_data;
        r_main_ctrl_p1 <= in_ctrl;
        r_main_dst_p1  <= in_DstReg;
      end else if (w_ld_main_skid) begin
        r_main_data_p1 <= r_skid_data_p1;
        r_main_ctrl_p1 <= r_skid_ctrl_p1;
        r_main_dst_p1  <= r_skid_dst_p1;
      end
      if (w_ld_skid) begin
        r_skid_data_p1 <= in_data;
        r_skid_ctrl_p1 <= in_ctrl;
        r_skid_dst_p1  <= in_DstReg;
      end
      // A flushed slot must decode as a bubble, even though data/dst go stale.
      if (flush) begin
        r_main_ctrl_p1 <= '0;
        r_skid_ctrl_p1 <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_stall_cnt <= '0;
    else if (w_main_vld && !out_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
  end

  assign out_valid  = w_main_vld;
  assign out_data   = r_main_data_p1;
  assign out_DstReg = r_main_dst_p1;
  assign out_ctrl   = w_main_vld ? r_main_ctrl_p1 : '0;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [4:0]  in_ctrl;
  logic [3:0]  in_dst;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic [4:0]  a_out_ctrl;
  logic [3:0]  a_out_dst;
  logic [3:0]  a_stall_cnt;

  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [4:0]  b_out_ctrl;
  logic [3:0]  b_out_dst;
  logic [15:0] b_stall_cnt;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(16), .CTRL_W(5), .DST_W(4), .SKID(1), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_DstReg(in_dst), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .out_DstReg(a_out_dst), .stall_cnt(a_stall_cnt)
  );

  pipe_skid_stage #(.DATA_W(16), .CTRL_W(5), .DST_W(4), .SKID(0), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_DstReg(in_dst), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .out_DstReg(b_out_dst), .stall_cnt(b_stall_cnt)
  );

  // Reference model: each stage is a FIFO of bounded depth.
  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  c;
    logic [3:0]  r;
  } word_t;

  word_t qa[$];
  word_t qb[$];
  int    cnta;
  int    cntb;
  int    n_checks;
  int    n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] c,
                       input logic [3:0] r, input logic fl, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    in_dst    = r;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic check_outputs();
    chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
    chk("a_out_ctrl", 32'(a_out_ctrl), (qa.size() > 0) ? 32'(qa[0].c) : 32'd0);
    if (qa.size() > 0) begin
      chk("a_out_data", 32'(a_out_data), 32'(qa[0].d));
      chk("a_out_dst", 32'(a_out_dst), 32'(qa[0].r));
    end
    chk("a_stall_cnt", 32'(a_stall_cnt), 32'(cnta));
    chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
    chk("b_out_ctrl", 32'(b_out_ctrl), (qb.size() > 0) ? 32'(qb[0].c) : 32'd0);
    if (qb.size() > 0) begin
      chk("b_out_data", 32'(b_out_data), 32'(qb[0].d));
      chk("b_out_dst", 32'(b_out_dst), 32'(qb[0].r));
    end
    chk("b_stall_cnt", 32'(b_stall_cnt), 32'(cntb));
  endtask

  // One clock cycle with the inputs already driven; reports whether A accepted.
  task automatic tick(output bit acc_a);
    bit    ra, rb, acc_b;
    word_t w;
    #1;
    ra = (qa.size() < 2);
    rb = (qb.size() == 0) || out_ready;
    chk("a_in_ready", 32'(a_in_ready), 32'(ra));
    chk("b_in_ready", 32'(b_in_ready), 32'(rb));
    acc_a = in_valid && ra && !flush;
    acc_b = in_valid && rb && !flush;
    @(posedge clk);
    w.d = in_data;
    w.c = in_ctrl;
    w.r = in_dst;
    if (qa.size() > 0 && !out_ready) cnta = (cnta < 15) ? cnta + 1 : 15;
    if (qb.size() > 0 && !out_ready) cntb = (cntb < 65535) ? cntb + 1 : 65535;
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0 && out_ready) void'(qa.pop_front());
      if (acc_a) qa.push_back(w);
      if (qb.size() > 0 && out_ready) void'(qb.pop_front());
      if (acc_b) qb.push_back(w);
    end
    #1;
    check_outputs();
  endtask

  // Asserts reset between clock edges and checks that it clears immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    cnta = 0;
    cntb = 0;
    #1;
    check_outputs();
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int idx;
    n_checks = 0;
    n_errors = 0;
    cnta = 0;
    cntb = 0;
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b0, 1'b0);
    #12;
    check_outputs();
    chk("reset_a_in_ready", 32'(a_in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream five words with no backpressure.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 16'(i), 5'b00010, 4'(i), 1'b0, 1'b1);
      tick(acc);
    end
    drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b0, 1'b1);
    tick(acc);
    tick(acc);
    chk("stream_stall", 32'(a_stall_cnt), 32'd0);

    // Backpressure into the skid entry.
    async_reset();
    idx = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (idx < 4) drive(1'b1, 16'hA000 + 16'(idx), 5'b01001, 4'(idx), 1'b0, (cyc < 2 || cyc > 4));
      else         drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b0, 1'b1);
      tick(acc);
      if (acc) idx++;
      if (cyc == 3) chk("bp_in_ready_low", 32'(a_in_ready), 32'd0);
    end
    chk("bp_words_sent", 32'(idx), 32'd4);
    chk("bp_stall", 32'(a_stall_cnt), 32'd3);

    // Flush while FULL with a third word offered.
    async_reset();
    drive(1'b1, 16'hB000, 5'b00100, 4'h1, 1'b0, 1'b0);
    tick(acc);
    drive(1'b1, 16'hB001, 5'b00100, 4'h2, 1'b0, 1'b0);
    tick(acc);
    drive(1'b1, 16'hB002, 5'b00100, 4'h3, 1'b1, 1'b0);
    tick(acc);
    chk("flush_out_valid", 32'(a_out_valid), 32'd0);
    chk("flush_out_ctrl", 32'(a_out_ctrl), 32'd0);
    chk("flush_in_ready", 32'(a_in_ready), 32'd1);
    drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(acc);

    // SKID=0: combinational in_ready and simultaneous drain/load.
    async_reset();
    drive(1'b1, 16'hC000, 5'b10000, 4'h5, 1'b0, 1'b0);
    tick(acc);
    drive(1'b1, 16'hC001, 5'b10001, 4'h6, 1'b0, 1'b0);
    #1;
    chk("s0_in_ready_low", 32'(b_in_ready), 32'd0);
    tick(acc);
    drive(1'b1, 16'hC001, 5'b10001, 4'h6, 1'b0, 1'b1);
    #1;
    chk("s0_in_ready_high", 32'(b_in_ready), 32'd1);
    tick(acc);
    chk("s0_load_data", 32'(b_out_data), 32'hC001);
    drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(acc);

    // Asynchronous reset while FULL and stalling.
    async_reset();
    drive(1'b1, 16'hD000, 5'b00011, 4'h7, 1'b0, 1'b0);
    tick(acc);
    drive(1'b1, 16'hD001, 5'b00011, 4'h8, 1'b0, 1'b0);
    tick(acc);
    drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b0, 1'b0);
    tick(acc);
    async_reset();
    chk("ar_out_valid", 32'(a_out_valid), 32'd0);
    chk("ar_stall", 32'(a_stall_cnt), 32'd0);

    // Saturation of the 4-bit counter.
    drive(1'b1, 16'hE000, 5'b00001, 4'h9, 1'b0, 1'b0);
    tick(acc);
    drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(acc);
    chk("sat_stall", 32'(a_stall_cnt), 32'd15);
    drive(1'b0, 16'h0, 5'h0, 4'h0, 1'b1, 1'b0);
    tick(acc);
    chk("sat_after_flush", 32'(a_stall_cnt), 32'd15);

    // Randomized traffic.
    async_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 16'($urandom), 5'($urandom), 4'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6));
      tick(acc);
      if (i == 200) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised pipeline-stage register, the successor to our fixed-field inter-stage registers. It carries a data payload, control bits and a destination-register field between two pipeline stages, and adds a valid/ready handshake so either side can stall without losing words. An optional skid buffer registers the ready path. A flush input inserts a bubble. A saturating counter reports stall cycles. The block is intended for reuse at IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
DATA_W, 16, payload width (ALU result, store data, etc. concatenated by the instantiating stage)
CTRL_W, 5, control-bit width (MemWrite, MemRead, MemToReg, RegWrite, HLT); all-zero encoding is a bubble
DST_W, 4, destination-register field width
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, stall-counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word present
in_ready  output  1  stage can accept a word this cycle
in_data  input  DATA_W  upstream payload
in_ctrl  input  CTRL_W  upstream control bits
in_DstReg  input  DST_W  upstream destination register
flush  input  1  discard all held words (branch mispredict/exception)
out_valid  output  1  word present for downstream
out_ready  input  1  downstream accepts a word this cycle
out_data  output  DATA_W  held payload
out_ctrl  output  CTRL_W  held control bits; forced to 0 when out_valid=0
out_DstReg  output  DST_W  held destination register
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst_n=0, asynchronous): main and skid valid=0; all data/ctrl/DstReg registers=0; stall_cnt=0. Consequently out_valid=0 and out_ctrl=0. in_ready=1 after reset in both SKID modes. Reset asserted mid-transfer discards every word.
- Definitions: accept = in_valid & in_ready & ~flush; drain = out_valid & out_ready.
- Latency: a word accepted at edge N appears on the outputs after edge N (one cycle). Throughput is one word per cycle. Words leave in strict FIFO order; none are duplicated or dropped except by flush or reset.
- SKID=1 states, encoded by {skid_valid, main_valid}:
  - EMPTY: accept -> ONE (main <= in).
  - ONE: accept & out_ready -> ONE (main <= in); accept & ~out_ready -> FULL (skid <= in); ~accept & out_ready -> EMPTY; otherwise hold.
  - FULL: out_ready -> ONE (main <= skid); otherwise hold.
  - in_ready = ~skid_valid, taken directly from a flop with no combinational path from out_ready.
- SKID=0: single main register. in_ready = ~main_valid | out_ready (combinational). The FULL state does not exist.
- Flush: at the next edge, main_valid=0 and skid_valid=0, and the ctrl registers are cleared to 0. A word offered in the same cycle is dropped; upstream must treat the cycle as not accepted. Flush wins over any simultaneous accept or drain. Data/DstReg registers may keep stale values, but out_ctrl reads 0.
- out_ctrl gating: out_ctrl = main_ctrl when out_valid=1, else 0. This ensures a bubble never writes the register file or memory, or halts the core.
- out_valid = main_valid. Outputs change only on clock edges or asynchronous reset.
- stall_cnt: increments by 1 on each edge where out_valid & ~out_ready. It saturates at 2^CNT_W-1 with no wrap. It is cleared only by reset; flush does not clear it.

Test Plan:
- Reset then stream: release rst_n; drive in_valid=1 with data 0x0001..0x0005, ctrl=5'b00010, out_ready=1 -> out_valid first high 1 cycle after the first accept; out_data 0x0001..0x0005 on consecutive cycles; in_ready stays 1; stall_cnt=0.
- Backpressure/skid (SKID=1): stream 0xA000..0xA003 with out_ready=0 from cycle 2 -> exactly 2 words held (0xA000 in main, 0xA001 in skid); in_ready=0 the cycle after skid fills; raise out_ready after 3 stall cycles -> 0xA000, 0xA001, 0xA002, 0xA003 in order, no loss; stall_cnt=3.
- Flush: with FULL state holding 0xB000/0xB001 and in_valid=1 with 0xB002, pulse flush one cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xB002 never appears at the output.
- SKID=0 mode: hold out_ready=0 with the stage full -> in_ready=0 combinationally; assert out_ready=1 with in_valid=1 and 0xC001 in the same cycle -> 0xC000 drains and 0xC001 loads on that edge.
- Async reset mid-operation: drop rst_n between edges while FULL -> out_valid, out_ctrl and stall_cnt go to 0 immediately without waiting for a clock edge.
- Counter saturation (CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
